// File: rtl/eda_output_streamer.sv
// Snapshots the M x N regional-max bit-matrix on start and streams it out row by row
// as OUT_WIDTH-bit beats over a valid/ready handshake.
module eda_output_streamer #(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int I_WIDTH    = 4,
    parameter int BEAT_WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       start,
    input  logic [M-1:0][N-1:0]        matrix_in,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic [I_WIDTH-1:0]         out_row,
    output logic [BEAT_WIDTH-1:0]      out_beat,
    output logic                       out_last,
    output logic                       done
);

    localparam int BPR   = (N + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int PAD_W = BPR * OUT_WIDTH;
    localparam logic [I_WIDTH-1:0]    ROW_MAX  = I_WIDTH'(M - 1);
    localparam logic [BEAT_WIDTH-1:0] BEAT_MAX = BEAT_WIDTH'(BPR - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t                  state;
    logic [M-1:0][N-1:0]     snap;
    logic [I_WIDTH-1:0]      row;
    logic [BEAT_WIDTH-1:0]   beat;
    logic [PAD_W-1:0]        row_padded;
    logic [PAD_W-1:0]        row_shifted;

    assign out_row  = row;
    assign out_beat = beat;

    // Beat data is a pure function of registers; widening the row zero-fills columns >= N.
    // NOTE: every signal driven in always_comb gets a default first so no latch can be inferred.
    always_comb begin
        row_padded  = PAD_W'(snap[row]);
        row_shifted = row_padded >> (int'(beat) * OUT_WIDTH);
        out_data    = '0;
        if (out_valid) out_data = row_shifted[OUT_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            row       <= '0;
            beat      <= '0;
            // NOTE: the snapshot is reset to all 1s to mirror the upstream RAM's reset contents.
            snap      <= '1;
        end else if (clear) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            row       <= '0;
            beat      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    snap      <= matrix_in;
                    row       <= '0;
                    beat      <= '0;
                    out_valid <= 1'b1;
                    out_last  <= (M == 1) && (BPR == 1);
                    state     <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else if (beat == BEAT_MAX) begin
                            beat     <= '0;
                            row      <= row + 1'b1;
                            out_last <= (BPR == 1) && (row == ROW_MAX - 1'b1);
                        end else begin
                            beat     <= beat + 1'b1;
                            out_last <= (row == ROW_MAX) && (beat == BEAT_MAX - 1'b1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eda_output_streamer.sv
// Self-checking bench: a 2x12 instance for the directed/randomized frame tests and a default
// 16x16 instance for the all-ones reset-default frame, both checked against an arithmetic model.
module tb_eda_output_streamer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Small instance: M=2, N=12, OUT_WIDTH=8 -> BPR=2, 4 beats per frame.
    logic              s_clear = 1'b0, s_start = 1'b0, s_ready = 1'b0;
    logic [1:0][11:0]  s_matrix = '0;
    logic              s_busy, s_valid, s_last, s_done;
    logic [7:0]        s_data;
    logic [0:0]        s_row, s_beat;

    // Default instance: M=16, N=16, OUT_WIDTH=8 -> BPR=2, 32 beats per frame.
    logic              b_clear = 1'b0, b_start = 1'b0, b_ready = 1'b0;
    logic [15:0][15:0] b_matrix = '1;
    logic              b_busy, b_valid, b_last, b_done;
    logic [7:0]        b_data;
    logic [3:0]        b_row;
    logic [0:0]        b_beat;

    eda_output_streamer #(.M(2), .N(12), .OUT_WIDTH(8), .I_WIDTH(1), .BEAT_WIDTH(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .clear(s_clear), .start(s_start), .matrix_in(s_matrix),
        .busy(s_busy), .out_valid(s_valid), .out_ready(s_ready), .out_data(s_data),
        .out_row(s_row), .out_beat(s_beat), .out_last(s_last), .done(s_done)
    );

    eda_output_streamer dut_b (
        .clk(clk), .reset_n(reset_n), .clear(b_clear), .start(b_start), .matrix_in(b_matrix),
        .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data),
        .out_row(b_row), .out_beat(b_beat), .out_last(b_last), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: beat b of a row is just (row_value >> 8*b) truncated to 8 bits; columns past N read 0.
    function automatic logic [7:0] beat_of(input logic [31:0] row_value, input int b);
        logic [31:0] shifted;
        shifted = row_value >> (8 * b);
        return shifted[7:0];
    endfunction

    function automatic bit pick_ready(input int mode, input int idx, inout int stall);
        if (mode == 1) return bit'($urandom_range(0, 1));
        if (mode == 2 && idx == 1 && stall < 3) begin
            stall++;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles on beat (0,1).
    task automatic s_frame(input logic [1:0][11:0] m, input int mode, input bit scramble,
                           input bit poke_start);
        int  idx = 0;
        int  stall = 0;
        bit  seen_done = 0;
        @(negedge clk);
        s_matrix = m;
        s_start  = 1'b1;
        s_ready  = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        check("s_load_busy", 32'(s_busy), 32'd1);
        check("s_load_valid", 32'(s_valid), 32'd0);
        for (int c = 2; c < 60 && !seen_done; c++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (scramble) s_matrix = '0;
            if (idx == 4) begin
                seen_done = 1'b1;
                check("s_done_pulse", 32'(s_done), 32'd1);
                check("s_done_valid", 32'(s_valid), 32'd0);
                check("s_done_busy", 32'(s_busy), 32'd1);
                if (mode == 0) check("s_done_cycle", 32'(c), 32'd6);
                if (poke_start) s_start = 1'b1;
            end else begin
                check("s_valid", 32'(s_valid), 32'd1);
                check("s_done_early", 32'(s_done), 32'd0);
                check("s_data", 32'(s_data), 32'(beat_of(32'(m[idx / 2]), idx % 2)));
                check("s_row", 32'(s_row), 32'(idx / 2));
                check("s_beat", 32'(s_beat), 32'(idx % 2));
                check("s_last", 32'(s_last), 32'(idx == 3));
                s_ready = pick_ready(mode, idx, stall);
                if (s_ready) idx++;
                if (poke_start && idx == 2) s_start = 1'b1;
            end
        end
        if (!seen_done) check("s_timeout_beats", 32'(idx), 32'd5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            s_start = 1'b0;
            s_ready = 1'b0;
            check("s_after_busy", 32'(s_busy), 32'd0);
            check("s_after_done", 32'(s_done), 32'd0);
            check("s_after_valid", 32'(s_valid), 32'd0);
        end
    endtask

    task automatic b_frame(input logic [15:0][15:0] m, input int mode);
        int idx = 0;
        int stall = 0;
        int lasts = 0;
        bit seen_done = 0;
        @(negedge clk);
        b_matrix = m;
        b_start  = 1'b1;
        b_ready  = 1'b0;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 2; c < 400 && !seen_done; c++) begin
            @(negedge clk);
            if (idx == 32) begin
                seen_done = 1'b1;
                check("b_done_pulse", 32'(b_done), 32'd1);
                if (mode == 0) check("b_done_cycle", 32'(c), 32'd34);
            end else begin
                check("b_valid", 32'(b_valid), 32'd1);
                check("b_data", 32'(b_data), 32'(beat_of(32'(m[idx / 2]), idx % 2)));
                check("b_row", 32'(b_row), 32'(idx / 2));
                check("b_beat", 32'(b_beat), 32'(idx % 2));
                check("b_last", 32'(b_last), 32'(idx == 31));
                if (b_last) lasts++;
                b_ready = pick_ready(mode, idx, stall);
                if (b_ready) idx++;
            end
        end
        check("b_beats", 32'(idx), 32'd32);
        if (mode == 0) check("b_last_count", 32'(lasts), 32'd1);
        @(negedge clk);
        b_ready = 1'b0;
        check("b_after_done", 32'(b_done), 32'd0);
        check("b_after_busy", 32'(b_busy), 32'd0);
    endtask

    function automatic logic [15:0][15:0] rand_big();
        logic [15:0][15:0] m;
        for (int r = 0; r < 16; r++) m[r] = 16'($urandom);
        return m;
    endfunction

    function automatic logic [1:0][11:0] rand_small();
        logic [1:0][11:0] m;
        m[0] = 12'($urandom);
        m[1] = 12'($urandom);
        return m;
    endfunction

    logic [1:0][11:0] basic_m;

    initial begin
        basic_m = {12'h003, 12'hA5F};
        repeat (2) @(negedge clk);
        check("rst_s_valid", 32'(s_valid), 32'd0);
        check("rst_s_busy", 32'(s_busy), 32'd0);
        check("rst_s_done", 32'(s_done), 32'd0);
        check("rst_s_last", 32'(s_last), 32'd0);
        check("rst_s_data", 32'(s_data), 32'd0);
        check("rst_b_rowbeat", 32'({b_row, b_beat}), 32'd0);
        check("rst_b_data", 32'(b_data), 32'd0);
        reset_n = 1'b1;

        // Reset-default frame: all-ones matrix on the 16x16 instance.
        b_frame('1, 0);

        s_frame(basic_m, 0, 1'b0, 1'b0);   // basic stream
        s_frame(basic_m, 2, 1'b0, 1'b0);   // backpressure on beat (0,1)
        s_frame(basic_m, 0, 1'b1, 1'b0);   // snapshot isolation
        s_frame(basic_m, 0, 1'b0, 1'b1);   // start while busy (SEND and DONE)

        // Clear after the first handshake.
        @(negedge clk);
        s_matrix = rand_small();
        s_start  = 1'b1;
        s_ready  = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (2) @(negedge clk);
        check("clr_pre_beat", 32'(s_beat), 32'd1);
        s_clear = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
        s_ready = 1'b0;
        check("clr_valid", 32'(s_valid), 32'd0);
        check("clr_busy", 32'(s_busy), 32'd0);
        check("clr_done", 32'(s_done), 32'd0);
        check("clr_rowbeat", 32'({s_row, s_beat}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("clr_no_done", 32'(s_done), 32'd0);
        end
        s_frame(basic_m, 0, 1'b0, 1'b0);

        // Clear and start together: clear wins.
        @(negedge clk);
        s_clear = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_clear = 1'b0;
        s_start = 1'b0;
        check("clr_start_busy", 32'(s_busy), 32'd0);
        @(negedge clk);
        check("clr_start_idle", 32'(s_valid), 32'd0);

        for (int i = 0; i < 6; i++) s_frame(rand_small(), 1, 1'(i % 2), 1'b0);
        for (int i = 0; i < 3; i++) b_frame(rand_big(), 1);

        // Asynchronous reset mid-frame.
        @(negedge clk);
        b_matrix = rand_big();
        b_start  = 1'b1;
        b_ready  = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(b_valid), 32'd0);
        check("arst_busy", 32'(b_busy), 32'd0);
        check("arst_data", 32'(b_data), 32'd0);
        check("arst_rowbeat", 32'({b_row, b_beat}), 32'd0);
        @(negedge clk);
        check("arst_done", 32'(b_done), 32'd0);
        reset_n = 1'b1;
        b_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_no_done", 32'(b_done), 32'd0);
        s_frame(rand_small(), 1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/eda_output_streamer.md
Name: eda_output_streamer

Overview:
- Sits directly downstream of the output-RAM stage, which holds the M x N regional-max result bit-matrix (1 = pixel is a regional maximum).
- On `start`, the block snapshots the whole matrix and streams it out row by row as OUT_WIDTH-bit beats over a valid/ready handshake.
- The snapshot lets the upstream stage be cleared and reloaded for the next image while readout continues.

Parameters:
- M, 16, number of image rows.
- N, 16, number of image columns.
- OUT_WIDTH, 8, data bits per output beat (1..N).
- I_WIDTH, 4, row index width; must satisfy 2^I_WIDTH >= M.
- BEAT_WIDTH, 1, beat-in-row index width; must satisfy 2^BEAT_WIDTH >= BPR, where BPR = ceil(N/OUT_WIDTH).

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns the block to IDLE.
- start  input  1  single-cycle request to snapshot and stream the matrix.
- matrix_in  input  [M-1:0][N-1:0]  result matrix from the upstream output RAM.
- busy  output  1  high in LOAD, SEND and DONE.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  OUT_WIDTH  pixel flags for the current beat.
- out_row  output  I_WIDTH  row index of the current beat.
- out_beat  output  BEAT_WIDTH  beat index within the row.
- out_last  output  1  marks the final beat of the frame (row M-1, beat BPR-1).
- done  output  1  one-cycle pulse after the final beat handshake.

Behaviour:
- Reset (async, reset_n=0):
  - state = IDLE.
  - busy, out_valid, out_last and done = 0.
  - out_data, out_row and out_beat = 0.
  - Snapshot register is cleared to all 1s, matching the upstream reset value.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - start=1 -> LOAD; busy rises on the next cycle.
  - start while busy is ignored and not queued.
- LOAD (exactly 1 cycle):
  - snap <= matrix_in.
  - row and beat counters <= 0.
  - -> SEND.
  - Latency from start to first out_valid is therefore 2 cycles.
- SEND:
  - out_valid = 1.
  - out_data[k] = snap[row][beat*OUT_WIDTH + k] for every column index < N.
  - Bits with column index >= N are 0 (zero padding on the last beat of a row when N % OUT_WIDTH != 0).
  - out_data, out_row and out_beat are registered or derived from registers only. There is no combinational path from out_ready to out_data or out_valid.
  - A handshake occurs when out_valid && out_ready in the same cycle.
  - No handshake: all outputs hold stable.
  - Handshake, beat < BPR-1: beat++.
  - Handshake, beat == BPR-1 and row < M-1: beat <= 0, row++.
  - Handshake with out_last=1: -> DONE; out_valid is 0 next cycle.
  - out_last = (row == M-1) && (beat == BPR-1).
- DONE (1 cycle):
  - done = 1, busy = 1.
  - -> IDLE.
  - A start arriving in DONE is ignored.
- Total beats per frame = M*BPR. The minimum frame time with out_ready held high is M*BPR + 2 cycles from start to done.
- matrix_in changes after LOAD have no effect on the stream (snapshot isolation).
- clear:
  - Highest priority after reset: the next state is IDLE from any state.
  - out_valid, out_last and done drop the next cycle; counters go to 0.
  - The snapshot is left unchanged.
  - If clear and start are high in the same cycle, clear wins and start is dropped.
- Reset asserted mid-frame: outputs go to their reset values immediately (asynchronous); no done pulse is produced.
- Counter wrap: row and beat never exceed M-1 and BPR-1; there is no modulo wrap beyond the frame.

Test Plan:
- Basic stream, M=2, N=12, OUT_WIDTH=8 (BPR=2), out_ready=1:
  - matrix row0 = 12'hA5F, row1 = 12'h003; pulse start.
  - Required beats: (row0, beat0, 8'h5F), (0, 1, 8'h0A), (1, 0, 8'h03), (1, 1, 8'h00, last=1).
  - done is high exactly 1 cycle after the last handshake; the start-to-done span is 6 cycles.
- Backpressure, same config:
  - Drop out_ready for 3 cycles while on beat (0, 1).
  - Required: out_data stays 8'h0A, out_valid stays 1, out_beat stays 1.
  - Stream then resumes with no beat lost or duplicated.
- Snapshot isolation:
  - After LOAD, force matrix_in to all 0.
  - Required: all streamed beats still show the pre-start values (row0 = 12'hA5F, row1 = 12'h003).
- Start while busy:
  - Pulse start during SEND and again during DONE.
  - Required: exactly one frame of 4 beats and one done pulse.
- Clear mid-frame:
  - Assert clear after the first handshake.
  - Required next cycle: out_valid = 0, busy = 0, no done pulse.
  - A subsequent start streams from (row0, beat0).
- Reset default:
  - After reset, pulse start with matrix_in tied to all 1s, M=16, N=16, OUT_WIDTH=8.
  - Required: 32 beats, each 8'hFF.
  - out_last is high only on (row 15, beat 1).
